// File: rtl/group_b_port_handshake_pkg.sv
// Shared PPI Group B types: operating mode, port direction and handshake state.
package ppi_pkg;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    ACKED = 2'd2
  } hs_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/group_b_port_handshake_if.sv
// Port B CPU/pin bundle; master is the CPU/pin side, slave is the Group B engine.
interface group_b_port_handshake_if;
  logic       cfg_wr;
  logic       cfg_mode_b;
  logic       cfg_dir_b;
  logic       inte_wr;
  logic       inte_val;
  logic       wr_b;
  logic       rd_b;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] pb_in;
  logic [7:0] pb_out;
  logic       pb_oe;
  logic       stb_ack_n;
  logic       pc1;
  logic       intr;

  modport master (
    output cfg_wr, cfg_mode_b, cfg_dir_b, inte_wr, inte_val, wr_b, rd_b, din,
    output pb_in, stb_ack_n,
    input  dout, pb_out, pb_oe, pc1, intr
  );

  modport slave (
    input  cfg_wr, cfg_mode_b, cfg_dir_b, inte_wr, inte_val, wr_b, rd_b, din,
    input  pb_in, stb_ack_n,
    output dout, pb_out, pb_oe, pc1, intr
  );
endinterface

// File: rtl/group_b_port_handshake_edge_sync.sv
// N-flop synchronizer for an idle-high async pin, with rise/fall pulses
// derived against a one-cycle-delayed copy of the synchronized level.
module ppi_edge_sync
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '1;
      prev_p <= 1'b1;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign rise = sync_p[SYNC_STAGES-1] & ~prev_p;
  assign fall = ~sync_p[SYNC_STAGES-1] & prev_p;

endmodule

// File: rtl/group_b_port_handshake.sv
// Group B Port B datapath with mode-0 basic I/O and mode-1 strobed handshake
// (STB#/IBF for input, OBF#/ACK# for output) plus INTR_B generation.
module group_b_port_handshake
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  group_b_port_handshake_if.slave  bus
);

  mode_e     mode_q, mode_d;
  dir_e      dir_q, dir_d;
  hs_state_e state_q, state_d;
  logic      inte_q, inte_d;
  logic      pc1_q, pc1_d;
  logic      intr_q, intr_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] pb_p [SYNC_STAGES];
  logic       sa_rise, sa_fall;

  ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.stb_ack_n),
    .rise (sa_rise),
    .fall (sa_fall)
  );

  // Pin data pipeline matches the strobe synchronizer depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) pb_p[i] <= '0;
    end else begin
      pb_p[0] <= bus.pb_in;
      for (int i = 1; i < SYNC_STAGES; i++) pb_p[i] <= pb_p[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE0;
      dir_q   <= DIR_IN;
      state_q <= IDLE;
      inte_q  <= 1'b0;
      pc1_q   <= 1'b0;
      intr_q  <= 1'b0;
      latch_q <= '0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      inte_q  <= inte_d;
      pc1_q   <= pc1_d;
      intr_q  <= intr_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    state_d = state_q;
    inte_d  = inte_q;
    pc1_d   = pc1_q;
    intr_d  = intr_q;
    latch_d = latch_q;
    if (bus.cfg_wr) begin
      mode_d  = mode_e'(bus.cfg_mode_b);
      dir_d   = dir_e'(bus.cfg_dir_b);
      state_d = IDLE;
      inte_d  = 1'b0;
      intr_d  = 1'b0;
      latch_d = '0;
      // OBF# idles high in mode-1 output; pc1 is unused (0) otherwise
      pc1_d   = bus.cfg_mode_b & bus.cfg_dir_b;
    end else begin
      if (mode_q == MODE0) begin
        if (dir_q == DIR_OUT && bus.wr_b) latch_d = bus.din;
      end else if (dir_q == DIR_IN) begin
        if (sa_fall) begin
          latch_d = pb_p[SYNC_STAGES-1];
          pc1_d   = 1'b1;
          state_d = FULL;
          if (bus.rd_b) intr_d = 1'b0;
        end else if (bus.rd_b) begin
          pc1_d   = 1'b0;
          intr_d  = 1'b0;
          state_d = IDLE;
        end
        if (sa_rise && pc1_q && !bus.rd_b && inte_q) intr_d = 1'b1;
      end else begin
        if (bus.wr_b) begin
          latch_d = bus.din;
          pc1_d   = 1'b0;
          intr_d  = 1'b0;
          state_d = FULL;
        end else if (sa_fall && state_q == FULL) begin
          pc1_d   = 1'b1;
          state_d = ACKED;
        end else if (sa_rise && state_q == ACKED) begin
          if (inte_q) intr_d = 1'b1;
          state_d = IDLE;
        end
      end
      // A cleared INTE_B masks any interrupt raised in the same cycle
      if (bus.inte_wr) begin
        inte_d = bus.inte_val;
        if (!bus.inte_val) intr_d = 1'b0;
      end
    end
  end

  assign bus.pb_oe  = (dir_q == DIR_OUT);
  assign bus.pb_out = (dir_q == DIR_OUT) ? latch_q : '0;
  assign bus.dout   = (mode_q == MODE0 && dir_q == DIR_IN) ? pb_p[SYNC_STAGES-1] : latch_q;
  assign bus.pc1    = pc1_q;
  assign bus.intr   = intr_q;

endmodule

// File: tb/tb_group_b_port_handshake.sv
// Scoreboard bench for the Group B Port B handshake engine.
module tb_group_b_port_handshake;

  localparam int SYNC = 2;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } sb_item_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  sb_item_t sb_q[$];

  group_b_port_handshake_if bus ();

  group_b_port_handshake #(.SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [7:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, {24'd0, obs}, {24'd0, it.val});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic mode, input logic dir);
    bus.cfg_wr = 1'b1; bus.cfg_mode_b = mode; bus.cfg_dir_b = dir;
    tick(1);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic inte(input logic v);
    bus.inte_wr = 1'b1; bus.inte_val = v;
    tick(1);
    bus.inte_wr = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    bus.wr_b = 1'b1; bus.din = d;
    tick(1);
    bus.wr_b = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.cfg_wr = 0; bus.cfg_mode_b = 0; bus.cfg_dir_b = 0;
    bus.inte_wr = 0; bus.inte_val = 0; bus.wr_b = 0; bus.rd_b = 0;
    bus.din = '0; bus.pb_in = '0; bus.stb_ack_n = 1'b1;
    tick(2);
    check_eq("rst_pb_oe", 32'(bus.pb_oe), 32'd0);
    check_eq("rst_pb_out", 32'(bus.pb_out), 32'd0);
    check_eq("rst_pc1", 32'(bus.pc1), 32'd0);
    check_eq("rst_intr", 32'(bus.intr), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Mode 1 input: strobe in A5, interrupt on STB# rise, read clears
    cfg(1'b1, 1'b0);
    inte(1'b1);
    bus.pb_in = 8'hA5;
    tick(SYNC);
    bus.stb_ack_n = 1'b0;
    sb_push("m1in_dout", 8'hA5);
    tick(SYNC);
    check_eq("m1in_ibf_early", 32'(bus.pc1), 32'd0);
    tick(1);
    check_eq("m1in_ibf", 32'(bus.pc1), 32'd1);
    sb_pop_check(bus.dout);
    tick(1);
    bus.stb_ack_n = 1'b1;
    tick(SYNC);
    check_eq("m1in_intr_early", 32'(bus.intr), 32'd0);
    tick(1);
    check_eq("m1in_intr", 32'(bus.intr), 32'd1);
    bus.rd_b = 1'b1;
    #1;
    check_eq("m1in_rd_dout", 32'(bus.dout), 32'hA5);
    tick(1);
    bus.rd_b = 1'b0;
    check_eq("m1in_rd_ibf", 32'(bus.pc1), 32'd0);
    check_eq("m1in_rd_intr", 32'(bus.intr), 32'd0);

    // Mode 1 output: write, ACK# low/high, second write clears INTR
    cfg(1'b1, 1'b1);
    check_eq("m1out_obf_idle", 32'(bus.pc1), 32'd1);
    inte(1'b1);
    sb_push("m1out_pb_out", 8'h3C);
    write_b(8'h3C);
    sb_pop_check(bus.pb_out);
    check_eq("m1out_obf", 32'(bus.pc1), 32'd0);
    check_eq("m1out_oe", 32'(bus.pb_oe), 32'd1);
    bus.stb_ack_n = 1'b0;
    tick(SYNC + 1);
    check_eq("m1out_ack_obf", 32'(bus.pc1), 32'd1);
    tick(1);
    bus.stb_ack_n = 1'b1;
    tick(SYNC + 1);
    check_eq("m1out_intr", 32'(bus.intr), 32'd1);
    write_b(8'h77);
    check_eq("m1out_wr2_intr", 32'(bus.intr), 32'd0);
    check_eq("m1out_wr2_obf", 32'(bus.pc1), 32'd0);

    // Mode 1 input: rd_b coincides with detected STB# fall
    cfg(1'b1, 1'b0);
    inte(1'b1);
    bus.pb_in = 8'h5A;
    tick(SYNC);
    bus.stb_ack_n = 1'b0;
    sb_push("coll_dout", 8'h5A);
    tick(SYNC);
    bus.rd_b = 1'b1;
    tick(1);
    bus.rd_b = 1'b0;
    check_eq("coll_ibf", 32'(bus.pc1), 32'd1);
    check_eq("coll_intr", 32'(bus.intr), 32'd0);
    sb_pop_check(bus.dout);
    bus.stb_ack_n = 1'b1;
    tick(SYNC + 2);

    // Mode 1 output with INTE_B=0, then INTE_B clear while intr=1
    cfg(1'b1, 1'b1);
    write_b(8'h44);
    bus.stb_ack_n = 1'b0;
    tick(SYNC + 2);
    bus.stb_ack_n = 1'b1;
    tick(SYNC + 1);
    check_eq("noint_intr", 32'(bus.intr), 32'd0);
    inte(1'b1);
    check_eq("inte_set_no_intr", 32'(bus.intr), 32'd0);
    write_b(8'h55);
    bus.stb_ack_n = 1'b0;
    tick(SYNC + 2);
    bus.stb_ack_n = 1'b1;
    tick(SYNC + 1);
    check_eq("int2_intr", 32'(bus.intr), 32'd1);
    inte(1'b0);
    check_eq("inte_clr_intr", 32'(bus.intr), 32'd0);

    // Mode 0 output then mode 0 input
    cfg(1'b0, 1'b1);
    sb_push("m0out_pb_out", 8'hFF);
    write_b(8'hFF);
    sb_pop_check(bus.pb_out);
    check_eq("m0out_dout", 32'(bus.dout), 32'hFF);
    check_eq("m0out_oe", 32'(bus.pb_oe), 32'd1);
    check_eq("m0out_pc1", 32'(bus.pc1), 32'd0);
    cfg(1'b0, 1'b0);
    check_eq("m0in_oe", 32'(bus.pb_oe), 32'd0);
    bus.pb_in = 8'h12;
    sb_push("m0in_dout", 8'h12);
    tick(SYNC);
    sb_pop_check(bus.dout);
    cfg(1'b0, 1'b1);
    check_eq("m0_latch_cleared", 32'(bus.pb_out), 32'd0);

    // Asynchronous reset mid-FULL
    cfg(1'b1, 1'b1);
    inte(1'b1);
    write_b(8'h99);
    check_eq("pre_rst_oe", 32'(bus.pb_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_pb_oe", 32'(bus.pb_oe), 32'd0);
    check_eq("arst_pc1", 32'(bus.pc1), 32'd0);
    check_eq("arst_intr", 32'(bus.intr), 32'd0);
    check_eq("arst_dout", 32'(bus.dout), 32'd0);
    check_eq("arst_pb_out", 32'(bus.pb_out), 32'd0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
